// File: rtl/risc_pkg.sv
// Shared RISC field layout, opcodes and NOP encoding.
// Used by fetch, the IF/ID stage and decode.
package risc_pkg;
    localparam int OPC_W = 6;
    localparam int REG_W = 5;
    localparam int IMM_W = 16;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [OPC_W-1:0] OP_ALU    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI   = 6'b001000;
    localparam logic [OPC_W-1:0] OP_BRANCH = 6'b000100;

    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/inst_field_decode.sv
// Combinational split of an instruction into opcode, rs, rt and sign-extended imm.
// Zero latency; no flow control.
module inst_field_decode
    import risc_pkg::*;
#(
    parameter int INST_W = 32
) (
    input  logic [INST_W-1:0] inst,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [31:0]       imm_sext
);
    assign opcode   = inst[OPC_HI:OPC_LO];
    assign rs       = inst[RS_HI:RS_LO];
    assign rt       = inst[RT_HI:RT_LO];
    assign imm_sext = sext_imm(inst[IMM_HI:IMM_LO]);
endmodule

// File: rtl/if_id_stage.sv
// IF->ID skid buffer: entries decoded on push, head visible one edge after push.
// if_ready = not full (registered count only); flush empties the buffer at the next edge.
module if_id_stage
    import risc_pkg::*;
#(
    parameter int PC_W   = 11,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [INST_W-1:0]        if_inst,
    input  logic [PC_W-1:0]          if_pc,
    output logic                     if_ready,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [INST_W-1:0]        id_inst,
    output logic [PC_W-1:0]          id_pc,
    output logic [PC_W-1:0]          id_pc_plus1,
    output logic [OPC_W-1:0]         id_opcode,
    output logic [REG_W-1:0]         id_rs,
    output logic [REG_W-1:0]         id_rt,
    output logic [31:0]              id_imm,
    output logic [$clog2(DEPTH):0]   id_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus1;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [31:0]       imm;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    inst_field_decode #(.INST_W(INST_W)) u_decode (
        .inst     (if_inst),
        .opcode   (new_entry.opcode),
        .rs       (new_entry.rs),
        .rt       (new_entry.rt),
        .imm_sext (new_entry.imm)
    );

    assign new_entry.inst     = if_inst;
    assign new_entry.pc       = if_pc;
    assign new_entry.pc_plus1 = if_pc + PC_W'(1);

    assign if_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Wrong-path beats, including any arriving this cycle, are discarded.
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Stale entries stay in storage after pops/flush, so every field is masked.
    assign head        = mem[rd_ptr];
    assign id_inst     = id_valid ? head.inst     : NOP[INST_W-1:0];
    assign id_pc       = id_valid ? head.pc       : '0;
    assign id_pc_plus1 = id_valid ? head.pc_plus1 : '0;
    assign id_opcode   = id_valid ? head.opcode   : '0;
    assign id_rs       = id_valid ? head.rs       : '0;
    assign id_rt       = id_valid ? head.rt       : '0;
    assign id_imm      = id_valid ? head.imm      : '0;
    assign id_count    = count;
endmodule
